// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: single-cycle logic/arithmetic ops
// and iterative one-bit-per-cycle rotates/shifts.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sc_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             zero,
  output logic             pari,
  output logic             neq
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_ROR1 = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_RORN = 3'b101;
  localparam logic [2:0] OP_ROLN = 3'b110;
  localparam logic [2:0] OP_SRCN = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [2:0]       sh_op;
  logic             fill;
  logic             neq_pend;

  logic [SHW-1:0]   amount;
  logic             is_shift_op;
  logic             iterative;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] imm_rslt;
  logic             imm_c;
  logic [WIDTH-1:0] step_acc;
  logic             step_c;

  assign amount      = inB[SHW-1:0];
  assign is_shift_op = (op == OP_RORN) || (op == OP_ROLN) || (op == OP_SRCN);
  assign iterative   = is_shift_op && (amount != '0);
  assign accept      = start && (state != SHIFT);
  assign last_step   = (cnt == SHW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = iterative ? SHIFT : DONE;
        else        state_nxt = IDLE;
      end
      SHIFT:   if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle results; shift ops reaching here have amount==0
  always_comb begin
    sum      = {1'b0, inA} + {1'b0, inB} + (WIDTH+1)'(sc_i);
    diff     = {1'b0, inA} - {1'b0, inB} - (WIDTH+1)'(sc_i);
    imm_rslt = inA;
    imm_c    = 1'b0;
    case (op)
      OP_NAND: imm_rslt = ~(inA & inB);
      OP_ROR1: begin
        imm_rslt = {inA[0], inA[WIDTH-1:1]};
        imm_c    = inA[0];
      end
      OP_ADD: begin
        imm_rslt = sum[WIDTH-1:0];
        imm_c    = sum[WIDTH];
      end
      OP_SUB: begin
        imm_rslt = diff[WIDTH-1:0];
        imm_c    = diff[WIDTH];
      end
      OP_XOR:  imm_rslt = inA ^ inB;
      default: ;
    endcase
  end

  // One iteration of the latched shift op
  always_comb begin
    step_acc = {fill, acc[WIDTH-1:1]};
    step_c   = acc[0];
    case (sh_op)
      OP_RORN: step_acc = {acc[0], acc[WIDTH-1:1]};
      OP_ROLN: begin
        step_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
        step_c   = acc[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Datapath and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      sh_op    <= '0;
      fill     <= 1'b0;
      neq_pend <= 1'b0;
      rslt     <= '0;
      sc_o     <= 1'b0;
      zero     <= 1'b1;
      pari     <= 1'b0;
      neq      <= 1'b0;
    end else if (accept) begin
      if (iterative) begin
        acc      <= inA;
        cnt      <= amount;
        sh_op    <= op;
        fill     <= sc_i;
        neq_pend <= (inA != inB);
      end else begin
        rslt <= imm_rslt;
        sc_o <= imm_c;
        zero <= (imm_rslt == '0);
        pari <= ^imm_rslt;
        neq  <= (inA != inB);
      end
    end else if (state == SHIFT) begin
      acc <= step_acc;
      cnt <= cnt - SHW'(1);
      if (last_step) begin
        rslt <= step_acc;
        sc_o <= step_c;
        zero <= (step_acc == '0);
        pari <= ^step_acc;
        neq  <= neq_pend;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized scoreboard bench for seq_alu: driver pushes model predictions,
// a monitor pops and compares on every done pulse.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] inA, inB;
  logic       sc_i;
  logic       busy, done;
  logic [7:0] rslt;
  logic       sc_o, zero, pari, neq;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic        ci16;
  logic        busy16, done16;
  logic [15:0] rslt16;
  logic        sc_o16, zero16, pari16, neq16;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] r;
    logic       c, z, p, n;
    int         lat;
    int         t0;
  } exp_t;

  exp_t q[$];

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .sc_i(sc_i), .busy(busy), .done(done), .rslt(rslt), .sc_o(sc_o),
    .zero(zero), .pari(pari), .neq(neq)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .inA(a16), .inB(b16),
    .sc_i(ci16), .busy(busy16), .done(done16), .rslt(rslt16), .sc_o(sc_o16),
    .zero(zero16), .pari(pari16), .neq(neq16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour from the arithmetic definition of each op
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    exp_t e;
    int   amt = int'(b[2:0]);
    int   ai  = int'(a);
    int   t;
    e.c   = 1'b0;
    e.r   = a;
    e.lat = 1;
    case (o)
      3'd0: e.r = ~(a & b);
      3'd1: begin e.r = 8'((ai >> 1) | (ai << 7)); e.c = a[0]; end
      3'd2: begin t = ai + int'(b) + int'(ci); e.r = 8'(t); e.c = (t > 255); end
      3'd3: begin t = ai - int'(b) - int'(ci); e.r = 8'(t); e.c = (ai < int'(b) + int'(ci)); end
      3'd4: e.r = a ^ b;
      3'd5: if (amt != 0) begin
        e.r = 8'((ai >> amt) | (ai << (8 - amt))); e.c = e.r[7]; e.lat = 1 + amt;
      end
      3'd6: if (amt != 0) begin
        e.r = 8'((ai << amt) | (ai >> (8 - amt))); e.c = e.r[0]; e.lat = 1 + amt;
      end
      default: if (amt != 0) begin
        t = ai >> amt;
        if (ci) t = t | (255 - (255 >> amt));
        e.r = 8'(t); e.c = a[amt-1]; e.lat = 1 + amt;
      end
    endcase
    e.z  = (e.r == 8'h00);
    e.p  = ^e.r;
    e.n  = (a != b);
    e.t0 = cyc;
    return e;
  endfunction

  // Drive one request for a cycle; caller is away from the clock edge
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic ci);
    start = 1'b1; op = o; inA = a; inB = b; sc_i = ci;
    q.push_back(model(o, a, b, ci));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rslt", 32'(rslt), 32'h0);
    chk("rst_sc_o", 32'(sc_o), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_pari", 32'(pari), 32'h0);
    chk("rst_neq",  32'(neq),  32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rslt",    32'(rslt), 32'(e.r));
        chk("sc_o",    32'(sc_o), 32'(e.c));
        chk("zero",    32'(zero), 32'(e.z));
        chk("pari",    32'(pari), 32'(e.p));
        chk("neq",     32'(neq),  32'(e.n));
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    int t0;
    logic got;
    reset = 1'b1; start = 1'b0; op = '0; inA = '0; inB = '0; sc_i = 1'b0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ci16 = 1'b0;
    idle(2);
    chk_reset_vals();
    reset = 1'b0;
    idle(1);

    issue(3'd2, 8'hF0, 8'h20, 1'b1); wait_done(); idle(1);
    issue(3'd3, 8'h05, 8'h07, 1'b0); wait_done();
    issue(3'd3, 8'h07, 8'h07, 1'b0); wait_done(); idle(2);

    issue(3'd5, 8'h81, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_during_shift", 32'(busy), 32'd1);
    end
    wait_done(); idle(1);
    issue(3'd6, 8'h81, 8'h00, 1'b0); wait_done(); idle(1);
    issue(3'd7, 8'hF0, 8'h04, 1'b1); wait_done(); idle(1);

    // start pulsed mid-shift must be dropped
    issue(3'd5, 8'h81, 8'h05, 1'b0);
    start = 1'b1; op = 3'd4; inA = 8'h12; inB = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(); idle(8);

    issue(3'd2, 8'h01, 8'h02, 1'b0); wait_done();
    issue(3'd4, 8'hA5, 8'hFF, 1'b0); wait_done(); idle(1);

    // reset mid-RORN aborts without a done pulse
    issue(3'd5, 8'h81, 8'h06, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(1);
    q.delete();
    chk_reset_vals();
    reset = 1'b0;
    idle(10);

    for (int n = 0; n < 200; n++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    // WIDTH=16 full-width rotate
    start16 = 1'b1; op16 = 3'd5; a16 = 16'h0001; b16 = 16'h000F; ci16 = 1'b0;
    t0 = cyc;
    @(posedge clk); #1;
    start16 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done16) got = 1'b1;
    end
    chk("w16_done_seen", 32'(got), 32'd1);
    chk("w16_latency", 32'(cyc - t0), 32'd16);
    chk("w16_rslt", 32'(rslt16), 32'h0002);
    chk("w16_sc_o", 32'(sc_o16), 32'd0);
    chk("w16_pari", 32'(pari16), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
